// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port among NUM_REQ writeback
// requesters. Grants one requester per cycle and registers the winner onto the
// write port. Writes to x0 are suppressed. A flush blocks grants and squashes
// the output stage. A saturating counter tracks cycles with conflicting requests.
// Build option: define RF_WB_ARB_FIXED_PRIO_EN to select fixed priority, where
// the lowest index wins. When it is undefined (the default), arbitration is
// round-robin.
module rf_wb_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned XLEN    = 64,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   input  logic [NUM_REQ-1:0]      req_valid_i,
   input  logic [NUM_REQ*5-1:0]    req_rd_i,
   input  logic [NUM_REQ*XLEN-1:0] req_data_i,
   output logic [NUM_REQ-1:0]      req_ready_o,
   output logic                    wr_reg_en_o,
   output logic [4:0]              rd_o,
   output logic [XLEN-1:0]         wr_reg_data_o,
   output logic [CNT_W-1:0]        conflict_cnt_o
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   logic                 w_found;
   logic [IDX_W-1:0]     w_win;
   logic [4:0]           w_sel_rd;
   logic [XLEN-1:0]      w_sel_data;
   logic [NUM_REQ-1:0]   w_grant;
   logic                 w_multi;
   int unsigned          w_idx;

   logic                 r_wr_en;
   logic [4:0]           r_rd;
   logic [XLEN-1:0]      r_data;
   logic [CNT_W-1:0]     r_cnt;

`ifndef RF_WB_ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0]     r_ptr;
`endif

   // Winner search: the first valid requester in priority order, gated by flush and reset
   always_comb begin
      w_found    = 1'b0;
      w_win      = '0;
      w_sel_rd   = '0;
      w_sel_data = '0;
      w_idx      = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef RF_WB_ARB_FIXED_PRIO_EN
         w_idx = k;
`else
         w_idx = (32'(r_ptr) + 32'd1 + k) % NUM_REQ;
`endif
         if (!w_found && 1'(req_valid_i >> w_idx)) begin
            w_found    = 1'b1;
            w_win      = IDX_W'(w_idx);
            w_sel_rd   = 5'(req_rd_i >> (5 * w_idx));
            w_sel_data = XLEN'(req_data_i >> (XLEN * w_idx));
         end
      end
      if (flush_i || !rst_i) begin
         w_found = 1'b0;
      end
   end

   assign w_grant     = w_found ? (NUM_REQ'(1) << w_win) : '0;
   assign w_multi     = (req_valid_i & (req_valid_i - NUM_REQ'(1))) != '0;
   assign req_ready_o = w_grant;

   // Output stage: register the winner; x0 writes are accepted but not enabled
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wr_en <= 1'b0;
         r_rd    <= '0;
         r_data  <= '0;
      end else begin
         r_wr_en <= w_found && (w_sel_rd != 5'd0);
         if (w_found) begin
            r_rd   <= w_sel_rd;
            r_data <= w_sel_data;
         end
      end
   end

   // Saturating count of cycles with two or more requests outside a flush
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt <= '0;
      end else if (!flush_i && w_multi && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

`ifndef RF_WB_ARB_FIXED_PRIO_EN
   // Round-robin pointer: remembers the last winner and holds when there is no grant
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ptr <= IDX_W'(NUM_REQ - 1);
      end else if (w_found) begin
         r_ptr <= w_win;
      end
   end
`endif

   assign wr_reg_en_o    = r_wr_en;
   assign rd_o           = r_rd;
   assign wr_reg_data_o  = r_data;
   assign conflict_cnt_o = r_cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter. The driver predicts each grant from a
// behavioural model and queues the expected write. A separate monitor pops and
// compares entries as the write port presents them.
module tb_rf_wb_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned XL = 64;
   localparam int unsigned CW = 4;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              flush_i;
   logic [N-1:0]      req_valid_i;
   logic [N*5-1:0]    req_rd_i;
   logic [N*XL-1:0]   req_data_i;
   logic [N-1:0]      req_ready_o;
   logic              wr_reg_en_o;
   logic [4:0]        rd_o;
   logic [XL-1:0]     wr_reg_data_o;
   logic [CW-1:0]     conflict_cnt_o;

   rf_wb_arbiter #(.NUM_REQ(N), .XLEN(XL), .CNT_W(CW)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .flush_i        (flush_i),
      .req_valid_i    (req_valid_i),
      .req_rd_i       (req_rd_i),
      .req_data_i     (req_data_i),
      .req_ready_o    (req_ready_o),
      .wr_reg_en_o    (wr_reg_en_o),
      .rd_o           (rd_o),
      .wr_reg_data_o  (wr_reg_data_o),
      .conflict_cnt_o (conflict_cnt_o)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      int            stamp;
      bit            en;
      logic [4:0]    rd;
      logic [XL-1:0] data;
   } wr_t;

   wr_t           exp_q[$];
   bit            p_v[N];
   logic [4:0]    p_rd[N];
   logic [XL-1:0] p_data[N];
   int            last_win;
   int            m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arbitration: the first pending requester after the last winner (or the lowest index)
   function automatic int model_winner();
      for (int k = 0; k < N; k++) begin
         int i;
`ifdef RF_WB_ARB_FIXED_PRIO_EN
         i = k;
`else
         i = (last_win + 1 + k) % N;
`endif
         if (p_v[i]) return i;
      end
      return -1;
   endfunction

   // One clock: drive the pending requests, check ready/counter, queue the expected write
   task automatic run_cycle(input bit fl);
      int           w;
      int           nv;
      logic [N-1:0] er;
      @(posedge clk);
      #2;
      flush_i = fl;
      for (int i = 0; i < N; i++) begin
         req_valid_i[i]          = p_v[i];
         req_rd_i[i*5 +: 5]      = p_rd[i];
         req_data_i[i*XL +: XL]  = p_data[i];
      end
      @(negedge clk);
      w  = fl ? -1 : model_winner();
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      chk("ready", 64'(req_ready_o), 64'(er));
      chk("conflict_cnt", 64'(conflict_cnt_o), 64'(m_cnt));
      nv = 0;
      for (int i = 0; i < N; i++) nv += int'(p_v[i]);
      if (nv >= 2 && !fl && m_cnt < (1 << CW) - 1) m_cnt++;
      if (w >= 0) begin
         exp_q.push_back('{edge_cnt + 1, p_rd[w] != 5'd0, p_rd[w], p_data[w]});
         last_win = w;
         p_v[w]   = 1'b0;
      end
   endtask

   task automatic post(input int i, input logic [4:0] rd, input logic [XL-1:0] data);
      if (!p_v[i]) begin
         p_v[i]    = 1'b1;
         p_rd[i]   = rd;
         p_data[i] = data;
      end
   endtask

   task automatic drain();
      repeat (N) run_cycle(1'b0);
   endtask

   task automatic rand_phase(input int cycles);
      repeat (cycles) begin
         for (int i = 0; i < N; i++) begin
            if (!p_v[i] && $urandom_range(0, 99) < 60)
               post(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    {$urandom, $urandom});
         end
         run_cycle($urandom_range(0, 9) == 0);
      end
   endtask

   // Monitor: compare the write port against the queued expectations every cycle
   logic [4:0]    h_rd   = '0;
   logic [XL-1:0] h_data = '0;
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].stamp < edge_cnt) begin
            e = exp_q.pop_front();
            chk("missed_write", 64'(e.stamp), 64'(edge_cnt));
         end
         if (!rst_i) begin
            h_rd   = '0;
            h_data = '0;
            chk("rst_en", 64'(wr_reg_en_o), 64'd0);
         end else if (exp_q.size() > 0 && exp_q[0].stamp == edge_cnt) begin
            e = exp_q.pop_front();
            chk("wr_en", 64'(wr_reg_en_o), 64'(e.en));
            chk("rd", 64'(rd_o), 64'(e.rd));
            chk("wr_data", wr_reg_data_o, e.data);
            h_rd   = e.rd;
            h_data = e.data;
         end else begin
            chk("idle_en", 64'(wr_reg_en_o), 64'd0);
            chk("hold_rd", 64'(rd_o), 64'(h_rd));
            chk("hold_data", wr_reg_data_o, h_data);
         end
      end
   end

   initial begin
      rst_i       = 1'b0;
      flush_i     = 1'b0;
      req_valid_i = '1;
      req_rd_i    = '0;
      req_data_i  = '0;
      for (int i = 0; i < N; i++) begin
         p_v[i] = 1'b0; p_rd[i] = '0; p_data[i] = '0;
      end
      last_win = N - 1;
      m_cnt    = 0;

      // Reset state, with every requester valid to confirm that ready stays low
      #1;
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      chk("rst_wr_en", 64'(wr_reg_en_o), 64'd0);
      chk("rst_rd", 64'(rd_o), 64'd0);
      chk("rst_data", wr_reg_data_o, 64'd0);
      chk("rst_cnt", 64'(conflict_cnt_o), 64'd0);
      req_valid_i = '0;
      repeat (2) @(posedge clk);
      #2 rst_i = 1'b1;

      // Single request
      post(0, 5'd5, 64'hDEAD_BEEF);
      run_cycle(1'b0);
      run_cycle(1'b0);

      // Two requesters valid for four cycles
      repeat (4) begin
         post(0, 5'd1, {$urandom, $urandom});
         post(1, 5'd2, {$urandom, $urandom});
         run_cycle(1'b0);
      end
      drain();

      // Write to x0
      post(1, 5'd0, 64'h1234);
      run_cycle(1'b0);
      run_cycle(1'b0);

      // Flush with two requesters valid
      post(0, 5'd7, 64'h77);
      post(1, 5'd8, 64'h88);
      run_cycle(1'b1);
      drain();

      rand_phase(150);
      drain();

      // Twenty conflict cycles: the counter saturates at 15
      repeat (20) begin
         post(0, 5'($urandom_range(0, 31)), {$urandom, $urandom});
         post(1, 5'($urandom_range(0, 31)), {$urandom, $urandom});
         run_cycle(1'b0);
      end
      drain();
      chk("cnt_saturated", 64'(conflict_cnt_o), 64'd15);

      // Asynchronous reset while a write is on the port
      post(0, 5'd5, 64'hDEAD_BEEF);
      run_cycle(1'b0);
      @(posedge clk);
      #1;
      chk("pre_rst_en", 64'(wr_reg_en_o), 64'd1);
      #2 rst_i = 1'b0;
      #1;
      chk("async_rst_en", 64'(wr_reg_en_o), 64'd0);
      chk("async_rst_cnt", 64'(conflict_cnt_o), 64'd0);
      exp_q.delete();
      m_cnt    = 0;
      last_win = N - 1;
      for (int i = 0; i < N; i++) p_v[i] = 1'b0;
      req_valid_i = '0;
      repeat (2) @(posedge clk);
      #2 rst_i = 1'b1;

      // After release, requester 0 wins first
      post(0, 5'd3, 64'hA0);
      post(1, 5'd4, 64'hB1);
      run_cycle(1'b0);
      drain();

      rand_phase(150);
      drain();
      run_cycle(1'b0);
      run_cycle(1'b0);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (wr_reg_en / rd / wr_reg_data) among NUM_REQ writeback requesters, e.g. ALU, load unit and CSR unit.
- Selects one request per cycle using round-robin arbitration.
- Registers the winner onto the write port, so the register file sees a clean, one-cycle-delayed write.
- Suppresses writes to x0, supports pipeline flush, and keeps a saturating count of arbitration conflicts for performance analysis.

Parameters:
- NUM_REQ, 2, number of writeback requesters; legal range 2..8.
- XLEN, 64, register data width.
- CNT_W, 32, width of the conflict counter.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous flush; blocks all grants in the current cycle and squashes the output stage.
- req_valid_i  input  NUM_REQ  per-requester write request.
- req_rd_i  input  NUM_REQ*5  destination register; requester i uses bits [5i+4:5i].
- req_data_i  input  NUM_REQ*XLEN  write data; requester i uses slice i.
- req_ready_o  output  NUM_REQ  one-hot grant; combinational from valid, flush and pointer.
- wr_reg_en_o  output  1  register-file write enable.
- rd_o  output  5  register-file destination register.
- wr_reg_data_o  output  XLEN  register-file write data.
- conflict_cnt_o  output  CNT_W  saturating count of conflict cycles.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - wr_reg_en_o=0, rd_o=0, wr_reg_data_o=0, conflict_cnt_o=0.
  - Round-robin pointer ptr=NUM_REQ-1, so requester 0 has first priority.
  - req_ready_o=0 while reset is asserted.
- Handshake:
  - A transfer occurs when req_valid_i[i] & req_ready_o[i].
  - A requester keeps valid, rd and data stable until its transfer completes.
  - Valid must not depend on ready.
- Arbitration:
  - Search order is ptr+1, ptr+2, … modulo NUM_REQ; the first valid requester wins.
  - At most one bit of req_ready_o is high in any cycle.
  - ptr loads the winner index on a grant cycle; ptr holds on a no-grant cycle.
- Flush:
  - flush_i=1 forces req_ready_o=0.
  - The next edge clears wr_reg_en_o.
  - ptr and conflict_cnt_o are unchanged by a flush.
- Output stage, one cycle latency:
  - On a grant, the next edge loads rd_o=req_rd_i[w] and wr_reg_data_o=req_data_i[w].
  - On the same edge, wr_reg_en_o=(req_rd_i[w]!=0).
  - A write to x0 is accepted (ready asserted) but produces no write enable.
  - With no grant, wr_reg_en_o=0 on the next edge; rd_o and wr_reg_data_o hold their previous values.
- Conflict counter:
  - Increments by 1 on each edge where two or more valid bits are high and flush_i=0.
  - Saturates at all-ones; there is no wrap-around.
- Simultaneous same-rd requests are legal:
  - They are serialised in grant order, and the later grant's value is the final one written.
  - Ordering correctness across requesters is the issue logic's responsibility, not this block's.
- Sustained throughput is 1 write per cycle.
- A single continuously-valid requester is granted every cycle with no bubbles.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
- Reset asserted mid-operation clears the output stage immediately; the in-flight write is lost.

Optional Feature:
- Macro: RF_WB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index wins, ptr is not implemented, and requester 0 can starve the others.
- Undefined (default): round-robin as described in Behaviour.
- The conflict counter, flush and x0 handling are identical in both builds.

Test Plan:
- Reset then single request: req 0 valid, rd=5, data=0xDEAD_BEEF → ready0=1 in the same cycle; next cycle wr_reg_en_o=1, rd_o=5, wr_reg_data_o=0xDEAD_BEEF. conflict_cnt_o stays 0.
- Round-robin with both valid for 4 cycles, rd0=1 and rd1=2 → grant sequence 0,1,0,1; rd_o sequence 1,2,1,2, each one cycle late. conflict_cnt_o=4.
  - Fixed-prio build: grant sequence 0,0,0,0; req1 ready stays 0.
- x0 suppression: req 1 valid with rd=0, data=0x1234 → ready1=1; next cycle wr_reg_en_o=0 and ptr advances to 1.
- Flush: both valid with flush_i=1 for 1 cycle → ready=00 that cycle; next cycle wr_reg_en_o=0 and conflict_cnt_o unchanged.
  - Round-robin build, with ptr=1 (requester 1 last granted) entering the flush: requester 0 is granted first after the flush.
- Counter saturation with CNT_W=4: 20 conflict cycles → conflict_cnt_o=15 and holds at 15.
- Async reset mid-write: assert rst_i low between edges while wr_reg_en_o=1 → wr_reg_en_o=0 and conflict_cnt_o=0 without waiting for a clock edge.
  - After release, the first grant goes to req 0.
